// File: rtl/clken_gen.sv
// Clock-enable generator: fixed 1/2 MHz enables, CPU slot with 1 MHz bus stretch, programmable channel dividers.
// Optional CPU speed selection is compiled in with `define CLKEN_GEN_TURBO_EN.
module clken_gen #(
  parameter int CLK_DIV = 48,
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 6
) (
  input  logic                    clk_48m,
  input  logic                    reset,
  input  logic                    mhz1_enable,
  input  logic [1:0]              cpu_speed,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  output logic [7:0]              frame_cnt,
  output logic                    mhz1_clken,
  output logic                    mhz2_clken,
  output logic                    cpu_cycle,
  output logic                    cpu_clken,
  output logic                    cpu_phi0,
  output logic [NUM_CH-1:0]       ch_clken,
  output logic                    stretch_busy
);

  localparam logic [7:0] FRAME_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] HALF_LAST  = 8'(CLK_DIV / 2 - 1);
  localparam logic [7:0] PERIOD_S0  = 8'(CLK_DIV / 2);
  localparam logic [7:0] PERIOD_S1  = 8'(CLK_DIV / 4);
  localparam logic [7:0] PERIOD_S2  = 8'(CLK_DIV / 8);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_WAIT1M  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [7:0] r_frame;
  logic [7:0] r_phase;
  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic [1:0] w_speed;
  logic [7:0] w_period;
  logic [7:0] w_half;
  logic       w_frame_end;
  logic       w_mhz1;
  logic       w_mhz2;
  logic       w_cpu_cycle;
  logic       w_phi0;
  logic       w_cpu_grant;
  logic [NUM_CH-1:0] w_ch_hit;

  assign w_frame_end = (r_frame == FRAME_LAST);
  assign w_mhz1      = w_frame_end;
  assign w_mhz2      = w_frame_end || (r_frame == HALF_LAST);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every always_ff samples the pre-edge value of every other register.
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      r_frame <= 8'd0;
    end else if (w_frame_end) begin
      r_frame <= 8'd0;
    end else begin
      r_frame <= r_frame + 8'd1;
    end
  end

`ifdef CLKEN_GEN_TURBO_EN
  logic [1:0] r_speed;

  // Speed is latched on the last master cycle so it applies from frame slot 0.
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      r_speed <= 2'd0;
    end else if (w_frame_end) begin
      r_speed <= (cpu_speed == 2'd3) ? 2'd0 : cpu_speed;
    end
  end

  assign w_speed = r_speed;
`else
  logic w_unused_cpu_speed;

  assign w_speed            = 2'd0;
  assign w_unused_cpu_speed = ^cpu_speed;
`endif

  always_comb begin
    case (w_speed)
      2'd1:    w_period = PERIOD_S1;
      2'd2:    w_period = PERIOD_S2;
      default: w_period = PERIOD_S0;
    endcase
  end

  assign w_half = w_period >> 1;

  // Phase tracks frame_cnt mod P; P divides the frame, so it realigns at slot 0.
  always_ff @(posedge clk_48m) begin
    if (reset) begin
      r_phase <= 8'd0;
    end else if (w_frame_end || (r_phase == w_period - 8'd1)) begin
      r_phase <= 8'd0;
    end else begin
      r_phase <= r_phase + 8'd1;
    end
  end

  assign w_cpu_cycle = (r_phase == 8'd0);
  assign w_phi0      = (r_phase == 8'd0) || (r_phase > w_half);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_cpu_grant  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_cpu_cycle) begin
          if (mhz1_enable) begin
            w_state_next = ST_WAIT1M;
          end else begin
            w_cpu_grant = 1'b1;
          end
        end
      end
      ST_WAIT1M: begin
        if (w_mhz1) begin
          w_state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (w_cpu_cycle) begin
          w_cpu_grant  = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_48m) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_shadow;
    logic [DIV_W-1:0] w_div;

    assign w_div       = ch_div[i*DIV_W +: DIV_W];
    assign w_ch_hit[i] = (r_cnt == r_shadow);

    // Shadow reloads only at period end, so a new divide never truncates a period.
    always_ff @(posedge clk_48m) begin
      if (reset || w_ch_hit[i]) begin
        r_cnt    <= '0;
        r_shadow <= w_div;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

  // Outputs are forced low combinationally so they read 0 on the very first reset cycle.
  assign frame_cnt    = reset ? 8'd0 : r_frame;
  assign mhz1_clken   = w_mhz1 & ~reset;
  assign mhz2_clken   = w_mhz2 & ~reset;
  assign cpu_cycle    = w_cpu_cycle & ~reset;
  assign cpu_phi0     = w_phi0 & ~reset;
  assign cpu_clken    = w_cpu_grant & ~reset;
  assign stretch_busy = (r_state != ST_RUN) & ~reset;
  assign ch_clken     = w_ch_hit & {NUM_CH{~reset}};

endmodule

// File: tb/tb_clken_gen.sv
// Directed self-checking bench for clken_gen (CLK_DIV=48, NUM_CH=4, DIV_W=6).
// Works with or without CLKEN_GEN_TURBO_EN defined.
module tb_clken_gen;

  localparam int CLK_DIV = 48;
  localparam int NUM_CH  = 4;
  localparam int DIV_W   = 6;

`ifdef CLKEN_GEN_TURBO_EN
  localparam logic [1:0] SPD_SET = 2'd2;
  localparam int         P_FAST  = 6;
`else
  localparam logic [1:0] SPD_SET = 2'd1;
  localparam int         P_FAST  = 24;
`endif

  logic                    clk_48m = 1'b0;
  logic                    reset;
  logic                    mhz1_enable;
  logic [1:0]              cpu_speed;
  logic [NUM_CH*DIV_W-1:0] ch_div;
  logic [7:0]              frame_cnt;
  logic                    mhz1_clken;
  logic                    mhz2_clken;
  logic                    cpu_cycle;
  logic                    cpu_clken;
  logic                    cpu_phi0;
  logic [NUM_CH-1:0]       ch_clken;
  logic                    stretch_busy;

  int n_checks = 0;
  int n_errors = 0;

  clken_gen #(
    .CLK_DIV(CLK_DIV),
    .NUM_CH (NUM_CH),
    .DIV_W  (DIV_W)
  ) dut (
    .clk_48m     (clk_48m),
    .reset       (reset),
    .mhz1_enable (mhz1_enable),
    .cpu_speed   (cpu_speed),
    .ch_div      (ch_div),
    .frame_cnt   (frame_cnt),
    .mhz1_clken  (mhz1_clken),
    .mhz2_clken  (mhz2_clken),
    .cpu_cycle   (cpu_cycle),
    .cpu_clken   (cpu_clken),
    .cpu_phi0    (cpu_phi0),
    .ch_clken    (ch_clken),
    .stretch_busy(stretch_busy)
  );

  always #5 clk_48m = ~clk_48m;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic cyc(input int f, input int p);
    return (f % p) == 0;
  endfunction

  function automatic logic phi(input int f, input int p);
    int m;
    m = f % p;
    return (m == 0) || (m > p / 2);
  endfunction

  // Channel dividers 2,0,3,1 after reset: ch0 hits when t%3==2, ch1 always, ch2 t%4==3, ch3 t%2==1.
  function automatic logic [3:0] exp_ch(input int t, input logic b0);
    return {(t % 2) == 1, (t % 4) == 3, 1'b1, b0};
  endfunction

  // ch0 divide changes 2 -> 5 at t=49; the period ending at t=50 still uses 2.
  function automatic logic b0_pre(input int t);
    return (t <= 50) ? ((t % 3) == 2) : (((t - 50) % 6) == 0);
  endfunction

  task automatic check_tb(input string tag, input int f, input int p);
    check({tag, "_frame"}, 32'(frame_cnt), 32'(f));
    check({tag, "_mhz1"}, 32'(mhz1_clken), 32'(f == 47));
    check({tag, "_mhz2"}, 32'(mhz2_clken), 32'((f == 23) || (f == 47)));
    check({tag, "_cycle"}, 32'(cpu_cycle), 32'(cyc(f, p)));
    check({tag, "_phi0"}, 32'(cpu_phi0), 32'(phi(f, p)));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_frame"}, 32'(frame_cnt), 32'(0));
    check({tag, "_mhz1"}, 32'(mhz1_clken), 32'(0));
    check({tag, "_mhz2"}, 32'(mhz2_clken), 32'(0));
    check({tag, "_cycle"}, 32'(cpu_cycle), 32'(0));
    check({tag, "_clken"}, 32'(cpu_clken), 32'(0));
    check({tag, "_phi0"}, 32'(cpu_phi0), 32'(0));
    check({tag, "_ch"}, 32'(ch_clken), 32'(0));
    check({tag, "_busy"}, 32'(stretch_busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    mhz1_enable = 1'b0;
    cpu_speed   = 2'd0;
    ch_div      = {6'd1, 6'd3, 6'd0, 6'd2};

    for (int i = 0; i < 3; i++) begin
      @(negedge clk_48m);
      #1;
      check_zero("rst0");
    end

    // Frame 0: free run at speed 0 straight out of reset
    for (int k = 0; k < 48; k++) begin
      @(negedge clk_48m);
      if (k == 0) reset = 1'b0;
      #1;
      check_tb("f0", k, 24);
      check("f0_clken", 32'(cpu_clken), 32'(cyc(k, 24)));
      check("f0_busy", 32'(stretch_busy), 32'(0));
      check("f0_ch", 32'(ch_clken), 32'(exp_ch(k, b0_pre(k))));
    end

    // Frame 1: 1 MHz access from slot 0 stretches; ch0 divide changed mid-period
    for (int k = 0; k < 48; k++) begin
      @(negedge clk_48m);
      if (k == 0) mhz1_enable = 1'b1;
      if (k == 1) ch_div[5:0] = 6'd5;
      #1;
      check_tb("f1", k, 24);
      check("f1_clken", 32'(cpu_clken), 32'(0));
      check("f1_busy", 32'(stretch_busy), 32'(k != 0));
      check("f1_ch", 32'(ch_clken), 32'(exp_ch(48 + k, b0_pre(48 + k))));
    end

    // Frame 2: release at slot 0 regardless of mhz1_enable, then normal running
    for (int k = 0; k < 48; k++) begin
      @(negedge clk_48m);
      if (k == 1) mhz1_enable = 1'b0;
      #1;
      check_tb("f2", k, 24);
      check("f2_clken", 32'(cpu_clken), 32'(cyc(k, 24)));
      check("f2_busy", 32'(stretch_busy), 32'(k == 0));
      check("f2_ch", 32'(ch_clken), 32'(exp_ch(96 + k, b0_pre(96 + k))));
    end

    // Frame 3: speed request mid-frame must not act before the next frame
    for (int k = 0; k < 48; k++) begin
      @(negedge clk_48m);
      if (k == 10) cpu_speed = SPD_SET;
      #1;
      check_tb("f3", k, 24);
      check("f3_clken", 32'(cpu_clken), 32'(cyc(k, 24)));
      check("f3_ch", 32'(ch_clken), 32'(exp_ch(144 + k, b0_pre(144 + k))));
    end

    // Frame 4: new speed in effect (turbo build) or ignored (default build)
    for (int k = 0; k < 48; k++) begin
      @(negedge clk_48m);
      #1;
      check_tb("f4", k, P_FAST);
      check("f4_clken", 32'(cpu_clken), 32'(cyc(k, P_FAST)));
    end

    // Frame 5: speed 0 requested at slot 0 applies only from the next frame
    for (int k = 0; k < 48; k++) begin
      @(negedge clk_48m);
      if (k == 0) cpu_speed = 2'd0;
      #1;
      check_tb("f5", k, P_FAST);
      check("f5_clken", 32'(cpu_clken), 32'(cyc(k, P_FAST)));
    end

    // Frame 6: start a stretch, then reset at slot 30 while in WAIT1M
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_48m);
      if (k == 0) mhz1_enable = 1'b1;
      #1;
      check_tb("f6", k, 24);
      check("f6_clken", 32'(cpu_clken), 32'(0));
      check("f6_busy", 32'(stretch_busy), 32'(k != 0));
    end

    @(negedge clk_48m);
    reset       = 1'b1;
    mhz1_enable = 1'b0;
    #1;
    check_zero("rst1a");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_48m);
      #1;
      check_zero("rst1b");
    end

    // Frame 7: fresh start after reset, no deferred grant, channels resynchronised
    for (int k = 0; k < 48; k++) begin
      @(negedge clk_48m);
      if (k == 0) reset = 1'b0;
      #1;
      check_tb("f7", k, 24);
      check("f7_clken", 32'(cpu_clken), 32'(cyc(k, 24)));
      check("f7_busy", 32'(stretch_busy), 32'(0));
      check("f7_ch", 32'(ch_clken), 32'(exp_ch(k, (k % 6) == 5)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clken_gen.md
CLKEN_GEN -- requirements
Module: clken_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 48: master cycles per 1 MHz frame; legal values are multiples of 24 up to 255.
REQ-002 SHALL have parameter NUM_CH, default 4: number of programmable enable channels (1..8).
REQ-003 SHALL have parameter DIV_W, default 6: width of each channel divide value.
REQ-004 SHALL have port clk_48m, input, 1: single master clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port mhz1_enable, input, 1: current CPU access targets the 1 MHz bus.
REQ-007 SHALL have port cpu_speed, input, 2: 0 = 2 MHz, 1 = 4 MHz, 2 = 8 MHz, 3 = treated as 0.
REQ-008 SHALL have port ch_div, input, NUM_CH*DIV_W: per-channel period minus 1; channel i uses bits [i*DIV_W +: DIV_W].
REQ-009 SHALL have port frame_cnt, output, 8: current master-cycle index, 0..CLK_DIV-1.
REQ-010 SHALL have ports mhz1_clken and mhz2_clken, output, 1 each: fixed 1 MHz and 2 MHz enables.
REQ-011 SHALL have ports cpu_cycle, cpu_clken and cpu_phi0, output, 1 each: CPU slot, granted CPU enable and phase-0 level.
REQ-012 SHALL have port ch_clken, output, NUM_CH: programmable channel enables.
REQ-013 SHALL have port stretch_busy, output, 1: high while a 1 MHz stretch is in progress.

Function
REQ-014 frame_cnt SHALL increment every clock and wrap from CLK_DIV-1 to 0.
REQ-015 mhz1_clken SHALL be high when frame_cnt == CLK_DIV-1. mhz2_clken SHALL be high when frame_cnt == CLK_DIV/2-1 or CLK_DIV-1.
REQ-016 The effective speed SHALL be sampled from cpu_speed only when frame_cnt == CLK_DIV-1. The sampled value applies from frame_cnt 0. Mid-frame changes are ignored until then.
REQ-017 CPU period P SHALL be CLK_DIV/2, CLK_DIV/4 or CLK_DIV/8 for effective speed 0, 1 or 2.
REQ-018 cpu_cycle SHALL be high when (frame_cnt mod P) == 0.
REQ-019 cpu_phi0 SHALL be high when (frame_cnt mod P) == 0 or (frame_cnt mod P) > P/2.
REQ-020 Stretch FSM states: RUN, WAIT1M, RELEASE. stretch_busy SHALL be high in WAIT1M and RELEASE.
REQ-021 RUN: on cpu_cycle with mhz1_enable = 1, cpu_clken SHALL be 0 and the FSM SHALL move to WAIT1M. Otherwise cpu_clken = cpu_cycle.
REQ-022 WAIT1M: cpu_clken SHALL be 0. On mhz1_clken the FSM SHALL move to RELEASE.
REQ-023 RELEASE: the next cpu_cycle SHALL produce cpu_clken = 1 regardless of mhz1_enable, and the FSM SHALL return to RUN.
REQ-024 If cpu_cycle and mhz1_clken coincide in WAIT1M, cpu_clken SHALL stay 0 and the FSM SHALL go to RELEASE.
REQ-025 A stretch in progress SHALL be unaffected by a speed change at a frame boundary. RELEASE waits for the first cpu_cycle of the new period.
REQ-026 Channel i SHALL hold a counter and a shadow divide value.
REQ-027 Channel counter behaviour:
- On a clock with counter == shadow: ch_clken[i] = 1, counter goes to 0, shadow loads ch_div[i].
- Otherwise: counter increments.
REQ-028 A ch_div change SHALL take effect only after the current channel period completes. Shadow 0 SHALL give ch_clken[i] high on every clock.
REQ-029 All enable outputs SHALL be combinational decodes of registered state, with zero-cycle latency from frame_cnt or the channel counters.

Reset
REQ-030 While reset is high, the block SHALL:
- force frame_cnt, every channel counter and all outputs to 0;
- set the FSM to RUN and effective speed to 0;
- load every shadow from ch_div each clock.
REQ-031 On the first clock after reset falls, frame_cnt SHALL be 0 and cpu_cycle SHALL be 1.
REQ-032 Reset asserted mid-stretch SHALL abandon the stretch. No deferred cpu_clken SHALL be emitted.

Configuration
REQ-033 Macro CLKEN_GEN_TURBO_EN, when defined, SHALL enable REQ-016/017 speed selection.
REQ-034 When CLKEN_GEN_TURBO_EN is undefined:
- cpu_speed SHALL be ignored;
- effective speed SHALL be fixed at 0 (P = CLK_DIV/2);
- no speed register SHALL be synthesised.

Verification (CLK_DIV=48, NUM_CH=4, DIV_W=6)
REQ-035 Free run, speed 0 -> cpu_cycle at frame_cnt 0 and 24; mhz2_clken at 23 and 47; mhz1_clken at 47; cpu_phi0 high at 0, 13..24 and 37..47.
REQ-036 Macro defined, cpu_speed = 2 set at frame_cnt 10 -> cpu_cycle every 6 cycles starting at frame_cnt 0 of the next frame, not earlier.
REQ-037 Speed 0, mhz1_enable = 1 at frame_cnt 0 -> cpu_clken 0 at 0 and 24; RELEASE entered at 47; cpu_clken 1 at next 0; stretch_busy high from cycle 1 through that 0.
REQ-038 ch_div[0] = 2, changed to 5 mid-period -> ch_clken[0] every 3 clocks until that period ends, then every 6 clocks.
REQ-039 Reset pulsed at frame_cnt 30 during WAIT1M -> all outputs 0 during reset; frame_cnt 0 and cpu_clken 1 on first clock after release; no extra cpu_clken.
REQ-040 Macro undefined, cpu_speed = 1 -> cpu_cycle remains at 0 and 24 only.
